// File: rtl/accel_stream_pkg.sv
// Shared definitions for the accelerator stream kernels.
// Contents:
//   state_t        - packet FSM encoding (IDLE=0, ACTIVE=1, TRAILER=2)
//   trailer layout - bit offsets and widths of the beats/seq/sum fields
//   byte_reverse64 - reverses the byte order of a 64-bit word
package accel_stream_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACTIVE  = 2'd1,
      ST_TRAILER = 2'd2
   } state_t;

   localparam int unsigned BEATS_W   = 16;
   localparam int unsigned SEQ_W     = 16;
   localparam int unsigned SUM_W     = 32;
   localparam int unsigned BEATS_LSB = 48;
   localparam int unsigned SEQ_LSB   = 32;
   localparam int unsigned SUM_LSB   = 0;

   localparam logic [BEATS_W-1:0] BEATS_MAX = '1;

   // Byte 0 swaps with byte 7, byte 1 with byte 6, and so on.
   function automatic logic [63:0] byte_reverse64(input logic [63:0] d);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         r[8*i +: 8] = d[8*(7-i) +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/axis_packet_checksum.sv
// Packet checksum stream kernel: forwards every 64-bit beat (optionally
// byte-reversed) and appends one trailer beat per packet carrying
// {beat count, sequence number, 32-bit additive checksum}.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   swap_en           - byte-reverse enable, latched on a packet's first beat
//   S_AXIS_*          - input stream (TDATA/TLAST/TVALID in, TREADY out)
//   M_AXIS_*          - output stream (TDATA/TLAST/TVALID out, TREADY in);
//                       TLAST marks trailer beats only
//   pkt_count         - number of trailers transferred (wraps)
//   busy              - packet open or output beat pending
//   cnt_sat           - sticky: some packet's beat count saturated
module axis_packet_checksum
   import accel_stream_pkg::*;
#(
   parameter int unsigned C_AXIS_DATA_WIDTH = 64,
   parameter int unsigned C_PKT_COUNT_WIDTH = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         swap_en,
   input  logic [C_AXIS_DATA_WIDTH-1:0] S_AXIS_TDATA,
   input  logic                         S_AXIS_TLAST,
   input  logic                         S_AXIS_TVALID,
   output logic                         S_AXIS_TREADY,
   output logic [C_AXIS_DATA_WIDTH-1:0] M_AXIS_TDATA,
   output logic                         M_AXIS_TLAST,
   output logic                         M_AXIS_TVALID,
   input  logic                         M_AXIS_TREADY,
   output logic [C_PKT_COUNT_WIDTH-1:0] pkt_count,
   output logic                         busy,
   output logic                         cnt_sat
);

   state_t                         state;
   state_t                         state_next;
   logic                           swap;
   logic [SUM_W-1:0]               sum;
   logic [BEATS_W-1:0]             beats;

   logic                           load_allowed;
   logic                           accept;
   logic                           start;
   logic                           swap_cur;
   logic                           trailer_load;
   logic                           sat_hit;
   logic [C_AXIS_DATA_WIDTH-1:0]   d;
   logic [C_AXIS_DATA_WIDTH-1:0]   trailer;
   logic [SUM_W-1:0]               sum_base;
   logic [SUM_W-1:0]               sum_upd;
   logic [BEATS_W-1:0]             beats_base;
   logic [BEATS_W-1:0]             beats_upd;

   logic [C_AXIS_DATA_WIDTH-1:0]   data_next;
   logic                           last_next;
   logic                           valid_next;
   logic                           busy_next;

   // Handshake qualifiers; input stalls only while the trailer is pending.
   assign load_allowed  = !M_AXIS_TVALID || M_AXIS_TREADY;
   assign S_AXIS_TREADY = !rst && (state != ST_TRAILER) && load_allowed;
   assign accept        = S_AXIS_TVALID && S_AXIS_TREADY;
   assign start         = accept && (state == ST_IDLE);
   assign trailer_load  = (state == ST_TRAILER) && load_allowed;

   // The first beat uses swap_en directly since swap is only latched on it.
   assign swap_cur = start ? swap_en : swap;
   assign d        = swap_cur ? byte_reverse64(S_AXIS_TDATA) : S_AXIS_TDATA;

   // A new packet restarts sum and count from the current beat.
   assign sum_base   = start ? '0 : sum;
   assign beats_base = start ? '0 : beats;
   assign sum_upd    = SUM_W'(sum_base + d[63:32] + d[31:0]);
   assign sat_hit    = (beats_base == BEATS_MAX);
   assign beats_upd  = sat_hit ? BEATS_MAX : BEATS_W'(beats_base + BEATS_W'(1));

   // Trailer word; beats/sum are frozen while in TRAILER.
   always_comb begin
      trailer                            = '0;
      trailer[BEATS_LSB +: BEATS_W]      = beats;
      trailer[SEQ_LSB   +: SEQ_W]        = pkt_count[SEQ_W-1:0];
      trailer[SUM_LSB   +: SUM_W]        = sum;
   end

   // Packet FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and next output-register contents.
   always_comb begin
      state_next = state;
      data_next  = M_AXIS_TDATA;
      last_next  = M_AXIS_TLAST;
      valid_next = M_AXIS_TVALID && !M_AXIS_TREADY;

      case (state)
         ST_IDLE, ST_ACTIVE: begin
            if (accept) begin
               state_next = S_AXIS_TLAST ? ST_TRAILER : ST_ACTIVE;
            end
         end
         ST_TRAILER: begin
            if (load_allowed) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase

      if (accept) begin
         data_next  = d;
         last_next  = 1'b0;
         valid_next = 1'b1;
      end else if (trailer_load) begin
         data_next  = trailer;
         last_next  = 1'b1;
         valid_next = 1'b1;
      end else if (load_allowed) begin
         last_next  = 1'b0;
      end

      busy_next = (state_next != ST_IDLE) || valid_next;
   end

   // Output register plus registered busy flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         M_AXIS_TDATA  <= '0;
         M_AXIS_TLAST  <= 1'b0;
         M_AXIS_TVALID <= 1'b0;
         busy          <= 1'b0;
      end else begin
         M_AXIS_TDATA  <= data_next;
         M_AXIS_TLAST  <= last_next;
         M_AXIS_TVALID <= valid_next;
         busy          <= busy_next;
      end
   end

   // Per-packet accumulator, swap latch and sticky saturation flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum     <= '0;
         beats   <= '0;
         swap    <= 1'b0;
         cnt_sat <= 1'b0;
      end else if (accept) begin
         sum   <= sum_upd;
         beats <= beats_upd;
         if (start) begin
            swap <= swap_en;
         end
         if (sat_hit) begin
            cnt_sat <= 1'b1;
         end
      end
   end

   // Counts trailers as they leave on the output handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pkt_count <= '0;
      end else if (M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST) begin
         pkt_count <= C_PKT_COUNT_WIDTH'(pkt_count + C_PKT_COUNT_WIDTH'(1));
      end
   end

endmodule

// File: tb/tb_axis_packet_checksum.sv
// Directed bench for axis_packet_checksum: per-scenario tasks with inline
// checks against hand-computed values; output beats are collected by a
// negedge monitor.
module tb_axis_packet_checksum;

   logic        clk = 1'b0;
   logic        rst;
   logic        swap_en;
   logic [63:0] S_AXIS_TDATA;
   logic        S_AXIS_TLAST;
   logic        S_AXIS_TVALID;
   logic        S_AXIS_TREADY;
   logic [63:0] M_AXIS_TDATA;
   logic        M_AXIS_TLAST;
   logic        M_AXIS_TVALID;
   logic        M_AXIS_TREADY;
   logic [31:0] pkt_count;
   logic        busy;
   logic        cnt_sat;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int tready_low = 0;
   int stab_err = 0;
   logic [64:0] out_q[$];
   int          out_cyc[$];

   logic        prev_stall = 1'b0;
   logic [63:0] prev_data = '0;
   logic        prev_last = 1'b0;

   axis_packet_checksum #(
      .C_AXIS_DATA_WIDTH(64),
      .C_PKT_COUNT_WIDTH(32)
   ) dut (
      .clk(clk), .rst(rst), .swap_en(swap_en),
      .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TLAST(S_AXIS_TLAST),
      .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY),
      .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TLAST(M_AXIS_TLAST),
      .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
      .pkt_count(pkt_count), .busy(busy), .cnt_sat(cnt_sat)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   // Collect output handshakes, count input stalls, watch output stability.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && (!M_AXIS_TVALID || M_AXIS_TDATA !== prev_data ||
                            M_AXIS_TLAST !== prev_last))
            stab_err = stab_err + 1;
         if (M_AXIS_TVALID && M_AXIS_TREADY) begin
            out_q.push_back({M_AXIS_TLAST, M_AXIS_TDATA});
            out_cyc.push_back(cyc);
         end
         if (!S_AXIS_TREADY) tready_low = tready_low + 1;
         prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
         prev_data  = M_AXIS_TDATA;
         prev_last  = M_AXIS_TLAST;
      end
   end

   function automatic logic [63:0] rev64(input logic [63:0] x);
      logic [63:0] r;
      for (int i = 0; i < 8; i++) r[63-8*i -: 8] = x[8*i +: 8];
      return r;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      S_AXIS_TVALID = 1'b0;
      S_AXIS_TLAST = 1'b0;
      S_AXIS_TDATA = '0;
      swap_en = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      out_q.delete();
      out_cyc.delete();
      tready_low = 0;
      stab_err = 0;
   endtask

   task automatic send_beat(input logic [63:0] data, input logic last, input logic sw);
      S_AXIS_TDATA = data;
      S_AXIS_TLAST = last;
      S_AXIS_TVALID = 1'b1;
      swap_en = sw;
      for (int w = 0; w < 1000; w++) begin
         @(negedge clk);
         if (S_AXIS_TREADY) begin
            @(posedge clk);
            #1;
            return;
         end
         @(posedge clk);
         #1;
      end
      tests++;
      fails++;
      $display("FAIL send_beat timeout data=%h", data);
   endtask

   task automatic wait_out(input int n, input int budget, input string tag);
      int k = 0;
      while (out_q.size() < n && k < budget) begin
         @(posedge clk);
         #1;
         k++;
      end
      tests++;
      if (out_q.size() < n) begin
         fails++;
         $display("FAIL %s drain timeout: got %0d beats, exp %0d", tag, out_q.size(), n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      swap_en = 1'b0;
      S_AXIS_TVALID = 1'b0;
      S_AXIS_TLAST = 1'b0;
      S_AXIS_TDATA = '0;
      M_AXIS_TREADY = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      tests++; if (M_AXIS_TVALID !== 1'b0) begin fails++; $display("FAIL reset_tvalid got %b exp 0", M_AXIS_TVALID); end
      tests++; if (M_AXIS_TLAST !== 1'b0) begin fails++; $display("FAIL reset_tlast got %b exp 0", M_AXIS_TLAST); end
      tests++; if (M_AXIS_TDATA !== 64'h0) begin fails++; $display("FAIL reset_tdata got %h exp 0", M_AXIS_TDATA); end
      tests++; if (S_AXIS_TREADY !== 1'b0) begin fails++; $display("FAIL reset_tready got %b exp 0", S_AXIS_TREADY); end
      tests++; if (pkt_count !== 32'h0) begin fails++; $display("FAIL reset_pkt_count got %0d exp 0", pkt_count); end
      tests++; if (busy !== 1'b0 || cnt_sat !== 1'b0) begin fails++; $display("FAIL reset_flags got busy=%b sat=%b exp 0 0", busy, cnt_sat); end
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      tests++; if (S_AXIS_TREADY !== 1'b1) begin fails++; $display("FAIL post_reset_tready got %b exp 1", S_AXIS_TREADY); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_two_beat();
      do_reset();
      M_AXIS_TREADY = 1'b1;
      send_beat(64'h00000001_00000002, 1'b0, 1'b0);
      tests++;
      if (M_AXIS_TVALID !== 1'b1 || M_AXIS_TDATA !== 64'h00000001_00000002) begin
         fails++; $display("FAIL two_beat_latency got v=%b d=%h exp v=1 d=0000000100000002", M_AXIS_TVALID, M_AXIS_TDATA);
      end
      send_beat(64'h00000003_00000004, 1'b1, 1'b0);
      S_AXIS_TVALID = 1'b0;
      wait_out(3, 50, "two_beat");
      repeat (2) begin @(posedge clk); #1; end
      tests++; if (out_q.size() !== 3) begin fails++; $display("FAIL two_beat_count got %0d exp 3", out_q.size()); end
      if (out_q.size() >= 3) begin
         tests++; if (out_q[0] !== {1'b0, 64'h00000001_00000002}) begin fails++; $display("FAIL two_beat_b0 got %h", out_q[0]); end
         tests++; if (out_q[1] !== {1'b0, 64'h00000003_00000004}) begin fails++; $display("FAIL two_beat_b1 got %h", out_q[1]); end
         tests++; if (out_q[2] !== {1'b1, 64'h0002_0000_0000000A}) begin fails++; $display("FAIL two_beat_trailer got %h exp 1_00020000_0000000a", out_q[2]); end
         tests++; if (out_cyc[2] - out_cyc[0] !== 2) begin fails++; $display("FAIL two_beat_rate got %0d cycles exp 2", out_cyc[2] - out_cyc[0]); end
      end
      tests++; if (pkt_count !== 32'd1) begin fails++; $display("FAIL two_beat_pkt_count got %0d exp 1", pkt_count); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL two_beat_busy got %b exp 0", busy); end
   endtask

   task automatic test_swap();
      do_reset();
      M_AXIS_TREADY = 1'b1;
      send_beat(64'h0102030405060708, 1'b1, 1'b1);
      S_AXIS_TVALID = 1'b0;
      swap_en = 1'b0;
      wait_out(2, 50, "swap");
      tests++; if (out_q.size() !== 2) begin fails++; $display("FAIL swap_count got %0d exp 2", out_q.size()); end
      if (out_q.size() >= 2) begin
         tests++; if (out_q[0] !== {1'b0, 64'h0807060504030201}) begin fails++; $display("FAIL swap_data got %h exp 0_0807060504030201", out_q[0]); end
         tests++; if (out_q[1] !== {1'b1, 64'h0001_0000_0C0A0806}) begin fails++; $display("FAIL swap_trailer got %h exp 1_00010000_0c0a0806", out_q[1]); end
      end
   endtask

   task automatic test_random();
      logic [64:0] exp_q[$];
      logic        stop;
      int          bad;
      do_reset();
      stop = 1'b0;
      fork
         begin
            for (int p = 0; p < 100; p++) begin
               int          len;
               logic        sw0;
               logic [31:0] sum;
               logic [63:0] data;
               logic [63:0] dd;
               len = $urandom_range(1, 64);
               sw0 = 1'($urandom_range(0, 1));
               sum = '0;
               for (int b = 0; b < len; b++) begin
                  data = {$urandom, $urandom};
                  send_beat(data, b == len - 1, (b == 0) ? sw0 : 1'($urandom_range(0, 1)));
                  dd = sw0 ? rev64(data) : data;
                  exp_q.push_back({1'b0, dd});
                  sum = sum + dd[63:32] + dd[31:0];
                  if ($urandom_range(0, 3) == 0) begin
                     S_AXIS_TVALID = 1'b0;
                     @(posedge clk);
                     #1;
                  end
               end
               exp_q.push_back({1'b1, 16'(len), 16'(p), sum});
            end
            S_AXIS_TVALID = 1'b0;
            wait_out(exp_q.size(), 30000, "random");
            stop = 1'b1;
         end
         begin
            while (!stop) begin
               @(posedge clk);
               #1;
               M_AXIS_TREADY = 1'($urandom_range(0, 1));
            end
            M_AXIS_TREADY = 1'b1;
         end
      join
      repeat (3) begin @(posedge clk); #1; end
      tests++; if (out_q.size() !== exp_q.size()) begin fails++; $display("FAIL random_count got %0d exp %0d", out_q.size(), exp_q.size()); end
      bad = -1;
      for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
         if (out_q[i] !== exp_q[i]) begin bad = i; break; end
      end
      tests++;
      if (bad >= 0) begin
         fails++; $display("FAIL random_stream idx %0d got %h exp %h", bad, out_q[bad], exp_q[bad]);
      end
      tests++; if (stab_err !== 0) begin fails++; $display("FAIL random_stability got %0d violations exp 0", stab_err); end
      tests++; if (pkt_count !== 32'd100) begin fails++; $display("FAIL random_pkt_count got %0d exp 100", pkt_count); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      M_AXIS_TREADY = 1'b1;
      for (int p = 0; p < 8; p++) send_beat({32'(p), 32'(p + 1)}, 1'b1, 1'b0);
      S_AXIS_TVALID = 1'b0;
      wait_out(16, 100, "b2b");
      repeat (2) begin @(posedge clk); #1; end
      tests++; if (tready_low !== 8) begin fails++; $display("FAIL b2b_stall got %0d cycles exp 8", tready_low); end
      tests++; if (out_q.size() !== 16) begin fails++; $display("FAIL b2b_count got %0d exp 16", out_q.size()); end
      if (out_q.size() >= 16) begin
         tests++; if (out_cyc[15] - out_cyc[0] !== 15) begin fails++; $display("FAIL b2b_rate got %0d cycles exp 15", out_cyc[15] - out_cyc[0]); end
         for (int p = 0; p < 8; p++) begin
            logic [64:0] e_d;
            logic [64:0] e_t;
            e_d = {1'b0, 32'(p), 32'(p + 1)};
            e_t = {1'b1, 16'd1, 16'(p), 32'(2 * p + 1)};
            tests++; if (out_q[2*p] !== e_d) begin fails++; $display("FAIL b2b_data%0d got %h exp %h", p, out_q[2*p], e_d); end
            tests++; if (out_q[2*p+1] !== e_t) begin fails++; $display("FAIL b2b_trailer%0d got %h exp %h", p, out_q[2*p+1], e_t); end
         end
      end
   endtask

   task automatic test_saturation();
      logic [31:0] sum;
      do_reset();
      M_AXIS_TREADY = 1'b1;
      tests++; if (cnt_sat !== 1'b0) begin fails++; $display("FAIL sat_initial got %b exp 0", cnt_sat); end
      sum = '0;
      for (int i = 0; i <= 65536; i++) begin
         send_beat({32'(i), 32'(i)}, i == 65536, 1'b0);
         sum = sum + 32'(2 * i);
      end
      S_AXIS_TVALID = 1'b0;
      wait_out(65538, 100, "sat");
      tests++;
      if (out_q.size() < 1 || out_q[out_q.size()-1] !== {1'b1, 16'hFFFF, 16'd0, sum}) begin
         fails++; $display("FAIL sat_trailer got %h exp %h", (out_q.size() > 0) ? out_q[out_q.size()-1] : 65'h0, {1'b1, 16'hFFFF, 16'd0, sum});
      end
      tests++; if (cnt_sat !== 1'b1) begin fails++; $display("FAIL sat_flag got %b exp 1", cnt_sat); end
      out_q.delete();
      send_beat(64'h00000010_00000020, 1'b1, 1'b0);
      S_AXIS_TVALID = 1'b0;
      wait_out(2, 50, "sat_next");
      tests++; if (out_q.size() < 2 || out_q[1] !== {1'b1, 16'd1, 16'd1, 32'h30}) begin fails++; $display("FAIL sat_next_trailer got %h exp 1_00010001_00000030", (out_q.size() > 1) ? out_q[1] : 65'h0); end
      tests++; if (cnt_sat !== 1'b1) begin fails++; $display("FAIL sat_sticky got %b exp 1", cnt_sat); end
      rst = 1'b1;
      #1;
      tests++; if (cnt_sat !== 1'b0) begin fails++; $display("FAIL sat_clear got %b exp 0", cnt_sat); end
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      M_AXIS_TREADY = 1'b1;
      send_beat(64'h00000005_00000006, 1'b1, 1'b0);
      S_AXIS_TVALID = 1'b0;
      wait_out(2, 50, "mid_pre");
      repeat (2) begin @(posedge clk); #1; end
      tests++; if (pkt_count !== 32'd1) begin fails++; $display("FAIL mid_pre_count got %0d exp 1", pkt_count); end
      for (int b = 0; b < 3; b++) send_beat({32'(b + 7), 32'(b)}, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      tests++; if (M_AXIS_TVALID !== 1'b0 || M_AXIS_TLAST !== 1'b0) begin fails++; $display("FAIL mid_rst_out got v=%b l=%b exp 0 0", M_AXIS_TVALID, M_AXIS_TLAST); end
      tests++; if (M_AXIS_TDATA !== 64'h0) begin fails++; $display("FAIL mid_rst_data got %h exp 0", M_AXIS_TDATA); end
      tests++; if (pkt_count !== 32'd0) begin fails++; $display("FAIL mid_rst_count got %0d exp 0", pkt_count); end
      tests++; if (busy !== 1'b0 || S_AXIS_TREADY !== 1'b0) begin fails++; $display("FAIL mid_rst_flags got busy=%b tready=%b exp 0 0", busy, S_AXIS_TREADY); end
      S_AXIS_TVALID = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      out_q.delete();
      out_cyc.delete();
      send_beat(64'h00000100_00000200, 1'b1, 1'b0);
      S_AXIS_TVALID = 1'b0;
      wait_out(2, 50, "mid_post");
      repeat (4) begin @(posedge clk); #1; end
      tests++; if (out_q.size() !== 2) begin fails++; $display("FAIL mid_post_count got %0d exp 2", out_q.size()); end
      tests++; if (out_q.size() < 2 || out_q[1] !== {1'b1, 16'd1, 16'd0, 32'h300}) begin fails++; $display("FAIL mid_post_trailer got %h exp 1_00010000_00000300", (out_q.size() > 1) ? out_q[1] : 65'h0); end
   endtask

   initial begin
      test_reset();
      test_two_beat();
      test_swap();
      test_random();
      test_back_to_back();
      test_saturation();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/axis_packet_checksum.md
# axis_packet_checksum

Stream kernel between the datamover's host-to-accelerator (MM2S) output stream and its accelerator-to-host (S2MM) input stream, in place of the loopback FIFO. It forwards every 64-bit beat of a packet, with optional byte reversal. After the last data beat of each packet it appends one trailer beat carrying the beat count, a packet sequence number and a 32-bit additive checksum. Full throughput except one input bubble per packet for the trailer.

## Interface
- C_AXIS_DATA_WIDTH, 64, stream width; only 64 is supported.
- C_PKT_COUNT_WIDTH, 32, width of the `pkt_count` status counter.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- swap_en  in  1  byte-reverse enable; sampled on the first accepted beat of each packet.
- S_AXIS_TDATA  in  64  input beat data.
- S_AXIS_TLAST  in  1  last beat of the input packet.
- S_AXIS_TVALID  in  1  input valid.
- S_AXIS_TREADY  out  1  input ready.
- M_AXIS_TDATA  out  64  output beat data.
- M_AXIS_TLAST  out  1  asserted only on trailer beats.
- M_AXIS_TVALID  out  1  output valid.
- M_AXIS_TREADY  in  1  output ready.
- pkt_count  out  C_PKT_COUNT_WIDTH  number of trailers transferred; wraps.
- busy  out  1  `state != IDLE || M_AXIS_TVALID`.
- cnt_sat  out  1  sticky; set when a beat count saturates.

## Operation
- Single output register: holds data, last and valid. Load is allowed when `!M_AXIS_TVALID || M_AXIS_TREADY`.
- States:
  - IDLE: no packet open.
  - ACTIVE: inside a packet.
  - TRAILER: last data beat has been taken; trailer is pending.
- `S_AXIS_TREADY = (state != TRAILER) && load_allowed`.
- Accepted beat:
  - `d = swap ? byte_reverse(S_AXIS_TDATA) : S_AXIS_TDATA`.
  - Load d into the output register with last = 0.
  - `sum <= sum + d[63:32] + d[31:0]` (mod 2^32).
  - `beats <= beats + 1`, 16-bit, saturating at 0xFFFF; saturation sets `cnt_sat`.
- Packet start (accept in IDLE):
  - Latch `swap <= swap_en`.
  - Sum and beat count start fresh from this beat.
- State transitions:
  - IDLE → ACTIVE on a non-last accept.
  - IDLE/ACTIVE → TRAILER on a last accept.
  - TRAILER → IDLE when the trailer is loaded.
- Trailer loads when in TRAILER and load is allowed:
  - [63:48] = beats.
  - [47:32] = `pkt_count[15:0]` at load time.
  - [31:0] = sum.
  - last = 1.
- `pkt_count` increments on `M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST`.
- The trailer is never byte-swapped.
- `S_AXIS_TLAST` is never forwarded onto data beats.

## Timing
- Reset values:
  - `M_AXIS_TVALID`, `M_AXIS_TLAST`: 0.
  - `M_AXIS_TDATA`: 0.
  - `S_AXIS_TREADY`: 0 while rst is high, 1 the first cycle after.
  - `pkt_count`, `cnt_sat`, `busy`: 0.
  - state: IDLE; sum, beats, swap: 0.
- Latency: input accept at cycle t → beat valid on M at t+1.
- Trailer is valid no earlier than one cycle after the last data beat is consumed. Input is stalled exactly while in TRAILER, which is one cycle when `M_AXIS_TREADY` is held high.
- Sustained rate: N data beats → N+1 output beats in N+1 cycles; the next packet's first beat is accepted in the cycle after the trailer loads.
- Back-to-back packets: the sum and count of packet k+1 never include beats of packet k.
- Under backpressure the output register holds data, last and valid stable until the handshake (AXI-Stream rule). No combinational path from `S_AXIS_TVALID` to `M_AXIS_TVALID`. `S_AXIS_TREADY` depends combinationally on `M_AXIS_TREADY`.
- Reset mid-packet: partial packet is discarded, no trailer is emitted, and `pkt_count` is cleared.
- A `swap_en` change mid-packet has no effect until the next packet.

## Structure
- Shared package `accel_stream_pkg`:
  - state encoding (IDLE=0, ACTIVE=1, TRAILER=2);
  - trailer field offsets (BEATS_LSB=48, SEQ_LSB=32, SUM_LSB=0);
  - `byte_reverse64` function.
- No sub-module; a single module containing the FSM, accumulator and output register.

## Test plan
- Two-beat packet `0x00000001_00000002`, `0x00000003_00000004` (last), `swap_en`=0, `M_AXIS_TREADY`=1:
  - output: the two beats with TLAST=0;
  - then trailer `0x0002_0000_0000000A` with TLAST=1;
  - `pkt_count`=1.
- `swap_en`=1, single beat `0x0102030405060708` (last):
  - output `0x0807060504030201`;
  - then trailer `0x0001_0000_0C0A0806`.
- Random `M_AXIS_TREADY` (50%), 100 packets of random length 1–64:
  - scoreboard data, trailers and sequence numbers 0..99;
  - no beat lost or duplicated;
  - outputs stable while stalled.
- Back-to-back single-beat packets with ready held high:
  - `S_AXIS_TREADY` is low exactly one cycle per packet;
  - sequence numbers increment by one per trailer.
- 65537-beat packet:
  - trailer [63:48]=0xFFFF;
  - `cnt_sat`=1 and stays 1 until reset.
- Assert rst after 3 beats of a 5-beat packet:
  - all outputs return to reset values immediately;
  - no trailer is emitted;
  - next packet's trailer carries sequence 0.
